sqrt_seq: RTL and testbench

Parametrised multi-cycle integer square-root unit that computes floor(sqrt(a)) and the remainder a - root^2 for an unsigned WIDTH-bit operand.
- Uses a bit-pair non-restoring scheme: an alignment phase, then one result bit per cycle.
- Successor to the fixed 32-bit sqrt block. Adds a width parameter, a remainder output, an abort input, fixed data-independent latency and optional rounding.
- Sits in the arithmetic datapath behind a start/busy/valid handshake.

---
 rtl/sqrt_pkg.sv | 16 +
 rtl/sqrt_seq_if.sv | 33 +++
 rtl/sqrt_step.sv | 29 ++
 rtl/sqrt_seq.sv | 117 +++++++++++
 tb/tb_sqrt_seq.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the sequential integer square-root unit.
// Optional build macro: SQRT_ROUND_EN (round-to-nearest root output).
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ITER  = 2'd2
  } sqrt_state_t;

  // Edges from the accepting edge to the edge that raises valid_o.
  function automatic int sqrt_latency(input int width);
    return width / 2 + 2;
  endfunction

endpackage

// File: rtl/sqrt_seq_if.sv
// Request/result bundle between a datapath master and the sqrt_seq unit.
// Optional build macro: SQRT_ROUND_EN (changes only the meaning of root_o).
interface sqrt_seq_if #(
  parameter int WIDTH = 32
);
  import sqrt_pkg::*;

  localparam int RW = WIDTH / 2;

  // Handshake: start_i is taken on a rising edge only while busy_o=0, and a_i
  // is sampled on that same edge. busy_o stays high until the result edge,
  // where valid_o rises and root_o/rem_o hold until the next accepted start.
  // abort_i while busy_o=1 returns to idle without touching valid_o/root_o/rem_o.
  logic          start_i;
  logic          abort_i;
  logic [WIDTH-1:0] a_i;
  logic          busy_o;
  logic          valid_o;
  logic [RW-1:0] root_o;
  logic [RW:0]   rem_o;
  sqrt_state_t   state_dbg;

  modport master (
    output start_i, abort_i, a_i,
    input  busy_o, valid_o, root_o, rem_o, state_dbg
  );

  modport slave (
    input  start_i, abort_i, a_i,
    output busy_o, valid_o, root_o, rem_o, state_dbg
  );

endinterface

// File: rtl/sqrt_step.sv
// One bit-pair non-restoring iteration: trial-subtract r+d from the partial
// remainder and shift the root/bit registers.
module sqrt_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] x_next,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] d_next
);

  logic [WIDTH-1:0] trial;

  // r and d never share set bits here, so this sum cannot carry out.
  assign trial = r + d;

  always_comb begin
    x_next = x;
    r_next = r >> 1;
    d_next = d >> 2;
    if (x >= trial) begin
      x_next = x - trial;
      r_next = (r >> 1) + d;
    end
  end

endmodule

// File: rtl/sqrt_seq.sv
// Multi-cycle floor(sqrt(a)) with remainder, fixed latency of WIDTH/2+2 edges.
// Optional build macro: SQRT_ROUND_EN (root_o rounds to nearest, saturating).
module sqrt_seq
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic      clk_i,
  input logic      rst_i,
  sqrt_seq_if.slave bus
);

  localparam int RW = WIDTH / 2;
  localparam logic [WIDTH-1:0] D_INIT = {2'b01, {(WIDTH - 2){1'b0}}};

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("sqrt_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  sqrt_state_t state, state_n;
  logic [WIDTH-1:0] x, x_n, r, r_n, d, d_n;
  logic [WIDTH-1:0] x_step, r_step, d_step;
  logic             valid, valid_n;
  logic [RW-1:0]    root, root_n, root_fin;
  logic [RW:0]      rem, rem_n;

  sqrt_step #(.WIDTH(WIDTH)) u_step (
    .x      (x),
    .r      (r),
    .d      (d),
    .x_next (x_step),
    .r_next (r_step),
    .d_next (d_step)
  );

`ifdef SQRT_ROUND_EN
  // rem > root means a >= root^2 + root + 1, i.e. sqrt(a) is past the midpoint.
  always_comb begin
    root_fin = r[RW-1:0];
    if (x > r && r[RW-1:0] != {RW{1'b1}}) root_fin = r[RW-1:0] + RW'(1);
  end
`else
  assign root_fin = r[RW-1:0];
`endif

  always_comb begin
    state_n = state;
    x_n     = x;
    r_n     = r;
    d_n     = d;
    valid_n = valid;
    root_n  = root;
    rem_n   = rem;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          x_n     = bus.a_i;
          r_n     = '0;
          d_n     = D_INIT;
          valid_n = 1'b0;
          state_n = ALIGN;
        end
      end
      ALIGN: begin
        // Leading zero bit-pairs are skipped here; each skip replaces an
        // iteration step, which keeps the total latency data-independent.
        if (bus.abort_i)            state_n = IDLE;
        else if (d != '0 && d > x)  d_n = d >> 2;
        else                        state_n = ITER;
      end
      ITER: begin
        if (bus.abort_i) begin
          state_n = IDLE;
        end else if (d != '0) begin
          x_n = x_step;
          r_n = r_step;
          d_n = d_step;
        end else begin
          root_n  = root_fin;
          rem_n   = x[RW:0];
          valid_n = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      x     <= '0;
      r     <= '0;
      d     <= '0;
      valid <= 1'b0;
      root  <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      x     <= x_n;
      r     <= r_n;
      d     <= d_n;
      valid <= valid_n;
      root  <= root_n;
      rem   <= rem_n;
    end
  end

  assign bus.busy_o    = (state != IDLE);
  assign bus.valid_o   = valid;
  assign bus.root_o    = root;
  assign bus.rem_o     = rem;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_sqrt_seq.sv
// Directed bench for sqrt_seq: a 32-bit instance for latency/handshake cases
// and an 8-bit instance swept over every operand in shuffled order.
module tb_sqrt_seq;
  import sqrt_pkg::*;

  localparam int LAT32 = sqrt_latency(32);
  localparam int LAT8  = sqrt_latency(8);

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic [63:0] exp_q[$];
  logic [63:0] last_root;
  logic [63:0] last_rem;

  sqrt_seq_if #(.WIDTH(32)) b32 ();
  sqrt_seq_if #(.WIDTH(8))  b8 ();

  sqrt_seq #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(b32));
  sqrt_seq #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(b8));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference rounding rule applied to a hand-computed floor root.
  function automatic logic [63:0] round_root(input logic [63:0] root, input logic [63:0] rem,
                                             input int rw);
    logic [63:0] rmax;
    rmax = (64'd1 << rw) - 64'd1;
`ifdef SQRT_ROUND_EN
    if (rem > root && root != rmax) return root + 64'd1;
`endif
    return root;
  endfunction

  // ---------------- driver tasks (32-bit unit) ----------------
  // Called at the negedge right after the accepting edge.
  task automatic wait_valid32(input string tag);
    int k;
    int busy_cnt;
    logic [63:0] e;
    k = 0;
    busy_cnt = 0;
    while (!b32.valid_o && k < LAT32 + 4) begin
      if (b32.busy_o) busy_cnt++;
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_latency"}, 64'(k), 64'(LAT32));
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT32));
    check_eq({tag, "_busy_low"}, 64'(b32.busy_o), 64'd0);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_exp_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_root"}, 64'(b32.root_o), {32'd0, e[63:32]});
      check_eq({tag, "_rem"},  64'(b32.rem_o),  {32'd0, e[31:0]});
      last_root = {32'd0, e[63:32]};
      last_rem  = {32'd0, e[31:0]};
    end
  endtask

  task automatic push_exp32(input logic [63:0] floor_root, input logic [63:0] rem);
    logic [63:0] rr;
    rr = round_root(floor_root, rem, 16);
    exp_q.push_back({rr[31:0], rem[31:0]});
  endtask

  task automatic run32(input string tag, input logic [31:0] a, input logic [63:0] floor_root,
                       input logic [63:0] rem, input bit with_abort);
    @(negedge clk);
    b32.start_i = 1'b1;
    b32.abort_i = with_abort;
    b32.a_i     = a;
    push_exp32(floor_root, rem);
    @(negedge clk);
    b32.start_i = 1'b0;
    b32.abort_i = 1'b0;
    wait_valid32(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order[256];
    n_cmp = 0;
    n_err = 0;
    last_root = 0;
    last_rem  = 0;
    rst = 1'b1;
    b32.start_i = 1'b0; b32.abort_i = 1'b0; b32.a_i = '0;
    b8.start_i  = 1'b0; b8.abort_i  = 1'b0; b8.a_i  = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  64'(b32.busy_o),  64'd0);
    check_eq("rst_valid", 64'(b32.valid_o), 64'd0);
    check_eq("rst_root",  64'(b32.root_o),  64'd0);
    check_eq("rst_rem",   64'(b32.rem_o),   64'd0);
    check_eq("rst_state", 64'(b32.state_dbg), 64'(IDLE));
    check_eq("rst8_valid", 64'(b8.valid_o), 64'd0);
    rst = 1'b0;

    // Basic operands, including the zero/one/all-ones boundaries.
    run32("a144",  32'd144,        64'd12,    64'd0,      1'b0);
    run32("a0",    32'd0,          64'd0,     64'd0,      1'b0);
    run32("a1",    32'd1,          64'd1,     64'd0,      1'b0);
    run32("amax",  32'hFFFF_FFFF,  64'd65535, 64'd131070, 1'b0);

    // Back-to-back with start held high; a_i changes while busy and is ignored.
    @(negedge clk);
    b32.start_i = 1'b1;
    b32.a_i     = 32'd2;
    push_exp32(64'd1, 64'd1);
    @(negedge clk);
    b32.a_i = 32'd99;
    wait_valid32("b2b_first");
    push_exp32(64'd9, 64'd18);
    @(negedge clk);
    b32.start_i = 1'b0;
    wait_valid32("b2b_second");

    // Abort mid-operation, with a simultaneous start that must lose.
    @(negedge clk);
    b32.start_i = 1'b1;
    b32.a_i     = 32'd1000;
    @(negedge clk);
    b32.start_i = 1'b0;
    repeat (4) @(negedge clk);
    b32.abort_i = 1'b1;
    b32.start_i = 1'b1;
    @(negedge clk);
    b32.abort_i = 1'b0;
    b32.start_i = 1'b0;
    check_eq("abort_busy",  64'(b32.busy_o),  64'd0);
    check_eq("abort_valid", 64'(b32.valid_o), 64'd0);
    check_eq("abort_root",  64'(b32.root_o),  last_root);
    check_eq("abort_rem",   64'(b32.rem_o),   last_rem);
    @(negedge clk);
    check_eq("abort_stay_idle", 64'(b32.busy_o), 64'd0);
    // Abort alone while idle does nothing.
    b32.abort_i = 1'b1;
    @(negedge clk);
    b32.abort_i = 1'b0;
    check_eq("idle_abort_busy", 64'(b32.busy_o), 64'd0);
    check_eq("idle_abort_root", 64'(b32.root_o), last_root);
    // Start together with abort in idle: start is accepted.
    run32("a1000_after_abort", 32'd1000, 64'd31, 64'd39, 1'b1);

    // Reset while iterating, then a normal operation.
    @(negedge clk);
    b32.start_i = 1'b1;
    b32.a_i     = 32'd12345;
    @(negedge clk);
    b32.start_i = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("pre_rst_state", 64'(b32.state_dbg), 64'(ITER));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy",  64'(b32.busy_o),  64'd0);
    check_eq("midrst_valid", 64'(b32.valid_o), 64'd0);
    check_eq("midrst_root",  64'(b32.root_o),  64'd0);
    check_eq("midrst_rem",   64'(b32.rem_o),   64'd0);
    run32("a144_after_rst", 32'd144, 64'd12, 64'd0, 1'b0);

    // 8-bit unit: every operand once, in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      int a;
      int fr;
      int k;
      logic [63:0] er;
      a = order[i];
      fr = 0;
      while ((fr + 1) * (fr + 1) <= a) fr++;
      er = round_root(64'(fr), 64'(a - fr * fr), 4);
      @(negedge clk);
      b8.start_i = 1'b1;
      b8.a_i     = 8'(a);
      @(negedge clk);
      b8.start_i = 1'b0;
      k = 0;
      while (!b8.valid_o && k < LAT8 + 4) begin
        @(negedge clk);
        k++;
      end
      check_eq($sformatf("w8_lat_a%0d", a),  64'(k), 64'(LAT8));
      check_eq($sformatf("w8_root_a%0d", a), 64'(b8.root_o), er);
      check_eq($sformatf("w8_rem_a%0d", a),  64'(b8.rem_o), 64'(a - fr * fr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
